multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 143 ++++++++++++++
 rtl/multicycle_control_alu_decoder.sv | 31 +++
 rtl/multicycle_control.sv | 110 +++++++++++
 tb/tb_multicycle_control.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the RV32I multicycle controller.
// Optional feature macro: ILLEGAL_TRAP_EN (TRAP state on illegal opcodes).
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        JAL,
        BEQ,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Per-state control word; strobes are gated later by inputs and reset.
    typedef struct packed {
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       mem_write;
        logic       reg_write;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALU;
                c.fetch      = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                c.result_src = RES_RDATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] s;
        case (op)
            OP_SW:   s = IMM_S;
            OP_BEQ:  s = IMM_B;
            OP_JAL:  s = IMM_J;
            default: s = IMM_I;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from alu_op and the instruction funct fields.
// Subtract only for R-type funct3=000 with funct7b5 set.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Select fixed add/sub or the funct-driven operation
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for an RV32I multicycle datapath with shared memory.
// Optional feature macro: ILLEGAL_TRAP_EN (park in TRAP on illegal opcode).
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_instr
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   pc_update;

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:    if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECR;
                    OP_IALU:      state_nxt = EXECI;
                    OP_JAL:       state_nxt = JAL;
                    OP_BEQ:       state_nxt = BEQ;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_nxt = TRAP;
`else
                        state_nxt = FETCH;
`endif
                    end
                endcase
            end
            MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_nxt = MEMWB;
            MEMWB:    state_nxt = FETCH;
            MEMWRITE: if (mem_ready) state_nxt = FETCH;
            EXECR:    state_nxt = ALUWB;
            EXECI:    state_nxt = ALUWB;
            ALUWB:    state_nxt = FETCH;
            JAL:      state_nxt = ALUWB;
            BEQ:      state_nxt = FETCH;
            TRAP:     state_nxt = TRAP;
            default:  state_nxt = FETCH;
        endcase
    end

    // State register with the control word registered alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= state_nxt;
            ctrl  <= state_ctrl(state_nxt);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_q;

    // Trap flag tracks entry into TRAP; cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= (state_nxt == TRAP);
    end

    assign illegal_instr = trap_q & ~rst;
`else
    assign illegal_instr = 1'b0;
`endif

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

    assign pc_update  = (ctrl.fetch & mem_ready) | ctrl.pc_update;
    assign pc_write   = ~rst & (pc_update | (ctrl.branch & zero));
    assign ir_write   = ~rst & ctrl.fetch & mem_ready;
    assign mem_write  = ~rst & ctrl.mem_write;
    assign reg_write  = ~rst & ctrl.reg_write;
    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign imm_src    = imm_sel(op);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction stream.
// Build with +define+ILLEGAL_TRAP_EN to exercise the TRAP variant.
module tb_multicycle_control;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ, P_TRAP
    } phase_e;

    typedef struct packed {
        logic       rst_only;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       reg_write, illegal_instr;

    exp_t   expq[$];
    phase_e phq[$];
    int     checks = 0;
    int     fails = 0;
    int     ncyc = 0;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // ALU operation expected for a register/immediate ALU instruction
    function automatic logic [2:0] ref_alu(logic [2:0] f3, logic f7, logic is_r);
        logic [2:0] r;
        if (f3 == 3'b000)      r = (is_r && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) r = 3'b101;
        else if (f3 == 3'b110) r = 3'b011;
        else if (f3 == 3'b111) r = 3'b010;
        else                   r = 3'b000;
        return r;
    endfunction

    // Expected outputs for one cycle of a given instruction phase
    function automatic exp_t model(phase_e p, logic [6:0] o, logic [2:0] f3,
                                   logic f7, logic z, logic mr, logic r);
        exp_t e;
        e = '0;
        if (o == 7'b0100011)      e.imm_src = 2'b01;
        else if (o == 7'b1100011) e.imm_src = 2'b10;
        else if (o == 7'b1101111) e.imm_src = 2'b11;
        else                      e.imm_src = 2'b00;
        if (r) begin
            e.rst_only = 1'b1;
            return e;
        end
        case (p)
            P_FETCH: begin
                e.alu_src_b = 2'b10; e.result_src = 2'b10;
                e.ir_write = mr; e.pc_write = mr;
            end
            P_DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            P_MEMADR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            P_MEMREAD:  e.adr_src = 1'b1;
            P_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            P_MEMWRITE: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            P_EXECR: begin
                e.alu_src_a = 2'b10;
                e.alu_control = ref_alu(f3, f7, 1'b1);
            end
            P_EXECI: begin
                e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
                e.alu_control = ref_alu(f3, f7, 1'b0);
            end
            P_ALUWB:    e.reg_write = 1'b1;
            P_JAL: begin
                e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
            end
            P_BEQ: begin
                e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z;
            end
            P_TRAP:     e.illegal = 1'b1;
            default:    e = e;
        endcase
        return e;
    endfunction

    function automatic logic [6:0] opc(int cls);
        logic [6:0] bad [4];
        logic [6:0] good [6];
        bad  = '{7'b0000000, 7'b0110111, 7'b1110011, 7'b1111111};
        good = '{7'b0000011, 7'b0100011, 7'b0110011,
                 7'b0010011, 7'b1101111, 7'b1100011};
        if (cls < 6) return good[cls];
        return bad[$urandom_range(0, 3)];
    endfunction

    // Drive one clock cycle of inputs and queue the expected response
    task automatic cyc(phase_e p, logic [6:0] o, logic [2:0] f3, logic f7,
                       logic mr, logic r, logic z);
        @(posedge clk);
        #1;
        rst = r; op = o; funct3 = f3; funct7b5 = f7;
        mem_ready = mr; zero = z;
        expq.push_back(model(p, o, f3, f7, z, mr, r));
        phq.push_back(p);
    endtask

    // One full instruction: cls 0 lw,1 sw,2 R,3 I,4 jal,5 beq,6 illegal
    task automatic run(int cls, logic [6:0] o, logic [2:0] f3, logic f7,
                       int fst, int mst, logic zb);
        repeat (fst) cyc(P_FETCH, o, f3, f7, 1'b0, 1'b0, rb());
        cyc(P_FETCH, o, f3, f7, 1'b1, 1'b0, rb());
        cyc(P_DECODE, o, f3, f7, rb(), 1'b0, rb());
        case (cls)
            0: begin
                cyc(P_MEMADR, o, f3, f7, rb(), 1'b0, rb());
                repeat (mst) cyc(P_MEMREAD, o, f3, f7, 1'b0, 1'b0, rb());
                cyc(P_MEMREAD, o, f3, f7, 1'b1, 1'b0, rb());
                cyc(P_MEMWB, o, f3, f7, rb(), 1'b0, rb());
            end
            1: begin
                cyc(P_MEMADR, o, f3, f7, rb(), 1'b0, rb());
                repeat (mst) cyc(P_MEMWRITE, o, f3, f7, 1'b0, 1'b0, rb());
                cyc(P_MEMWRITE, o, f3, f7, 1'b1, 1'b0, rb());
            end
            2: begin
                cyc(P_EXECR, o, f3, f7, rb(), 1'b0, rb());
                cyc(P_ALUWB, o, f3, f7, rb(), 1'b0, rb());
            end
            3: begin
                cyc(P_EXECI, o, f3, f7, rb(), 1'b0, rb());
                cyc(P_ALUWB, o, f3, f7, rb(), 1'b0, rb());
            end
            4: begin
                cyc(P_JAL, o, f3, f7, rb(), 1'b0, rb());
                cyc(P_ALUWB, o, f3, f7, rb(), 1'b0, rb());
            end
            5: cyc(P_BEQ, o, f3, f7, rb(), 1'b0, zb);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                repeat (3) cyc(P_TRAP, o, f3, f7, rb(), 1'b0, rb());
                cyc(P_TRAP, o, f3, f7, rb(), 1'b1, rb());
`endif
            end
        endcase
    endtask

    task automatic run_rand(int cls, int fst, int mst, logic zb);
        run(cls, opc(cls), 3'($urandom), rb(), fst, mst, zb);
    endtask

    // Monitor: compare DUT outputs against the queued expectation
    always @(negedge clk) begin
        exp_t e, a;
        phase_e p;
        logic ok;
        ncyc++;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            p = phq.pop_front();
            a = '0;
            a.pc_write = pc_write; a.adr_src = adr_src;
            a.mem_write = mem_write; a.ir_write = ir_write;
            a.result_src = result_src; a.alu_src_a = alu_src_a;
            a.alu_src_b = alu_src_b; a.alu_control = alu_control;
            a.imm_src = imm_src; a.reg_write = reg_write;
            a.illegal = illegal_instr;
            checks++;
            if (e.rst_only)
                ok = ({pc_write, ir_write, mem_write, reg_write,
                       illegal_instr} === 5'b0);
            else
                ok = (a === e);
            if (!ok) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h expected %h (rst_only=%0b)",
                         p.name(), ncyc, a, e, e.rst_only);
            end
        end
    end

    initial begin
        int cls;
        // reset
        cyc(P_FETCH, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(P_FETCH, 7'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        // lw, no stalls
        run(0, 7'b0000011, 3'b010, 1'b0, 0, 0, 1'b0);
        // sw with three stalled MEMWRITE cycles
        run(1, 7'b0100011, 3'b010, 1'b0, 0, 3, 1'b0);
        // beq taken, then not taken
        run(5, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1);
        run(5, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0);
        // funct decode corners
        run(2, 7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0);
        run(3, 7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0);
        run(2, 7'b0110011, 3'b010, 1'b0, 0, 0, 1'b0);
        run(3, 7'b0010011, 3'b110, 1'b0, 1, 0, 1'b0);
        run(2, 7'b0110011, 3'b111, 1'b1, 0, 0, 1'b0);
        run(4, 7'b1101111, 3'b000, 1'b0, 2, 0, 1'b0);
        // illegal opcode
        run(6, 7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
        // reset asserted while a load waits in MEMREAD
        cyc(P_FETCH, 7'b0000011, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(P_DECODE, 7'b0000011, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(P_MEMADR, 7'b0000011, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(P_MEMREAD, 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(P_MEMREAD, 7'b0000011, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        run(2, 7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0);
        // random stream
        for (int i = 0; i < 300; i++) begin
            cls = $urandom_range(0, 13);
            if (cls > 6) cls = cls - 7;
            if (cls == 6 && $urandom_range(0, 2) != 0) cls = 2;
            run_rand(cls,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                     rb());
        end
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
        #2;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
